ascii_hex_parser: RTL and testbench

Receives a byte stream of ASCII characters, one per handshake, and assembles hexadecimal digit strings into binary words; the inverse of the nibble-to-ASCII conversion used on the output side. Sits between the serial receive path and the debug/command logic, turning typed hex strings such as "1A2F\r" into a DATA_W-bit value with a valid/ready handshake. Flags malformed or overlong entries through a one-cycle error pulse.

---
 rtl/ascii_hex_parser.sv | 118 +++++++++++
 tb/tb_ascii_hex_parser.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ascii_hex_parser.sv
// ASCII hex string to binary word assembler: digits accumulate MSB-first,
// a CR/LF/space terminates. Optional macro ASCII_PARSER_LOWERCASE_EN admits 'a'-'f'.
module ascii_hex_parser #(
  parameter int DATA_W     = 32,
  parameter int MAX_DIGITS = DATA_W/4,
  localparam int CW        = $clog2(MAX_DIGITS+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              word_valid,
  output logic [DATA_W-1:0] word_data,
  input  logic              word_ready,
  output logic [CW-1:0]     digit_count,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD, DISCARD} state_t;

  localparam logic [CW-1:0] MAXC = CW'(MAX_DIGITS);

  state_t              state, state_nx;
  logic [DATA_W-1:0]   acc, acc_nx, wdata_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic                err_nx;
  logic                live;
  logic                is_dig, is_term, accept;
  logic [3:0]          nib;

  // Letters A-F (and a-f) carry 1..6 in their low nibble, so +9 gives 0xA..0xF.
  always_comb begin
    is_dig  = 1'b0;
    is_term = 1'b0;
    nib     = char_data[3:0];
    if (char_data >= 8'h30 && char_data <= 8'h39)
      is_dig = 1'b1;
    else if (char_data >= 8'h41 && char_data <= 8'h46) begin
      is_dig = 1'b1;
      nib    = char_data[3:0] + 4'd9;
    end
`ifdef ASCII_PARSER_LOWERCASE_EN
    else if (char_data >= 8'h61 && char_data <= 8'h66) begin
      is_dig = 1'b1;
      nib    = char_data[3:0] + 4'd9;
    end
`endif
    else if (char_data == 8'h0D || char_data == 8'h0A || char_data == 8'h20)
      is_term = 1'b1;
  end

  assign char_ready  = live && (state != HOLD);
  assign word_valid  = (state == HOLD);
  assign digit_count = cnt;
  assign accept      = char_valid && char_ready;

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    wdata_nx = word_data;
    err_nx   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (is_dig) begin
          acc_nx   = {{(DATA_W-4){1'b0}}, nib};
          cnt_nx   = CW'(1);
          state_nx = ACCUM;
        end else if (!is_term)
          state_nx = DISCARD;
      end
      ACCUM: if (accept) begin
        if (is_dig && cnt != MAXC) begin
          acc_nx = {acc[DATA_W-5:0], nib};
          cnt_nx = cnt + CW'(1);
        end else if (is_term) begin
          wdata_nx = acc;
          state_nx = HOLD;
        end else begin
          // overflow digit or illegal character: drop the whole entry
          acc_nx   = '0;
          cnt_nx   = '0;
          state_nx = DISCARD;
        end
      end
      HOLD: if (word_ready) begin
        acc_nx   = '0;
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      DISCARD: if (accept && is_term) begin
        err_nx   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      word_data <= '0;
      err       <= 1'b0;
      live      <= 1'b0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      word_data <= wdata_nx;
      err       <= err_nx;
      live      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Directed bench for ascii_hex_parser: hex strings in, words/err pulses checked.
module tb_ascii_hex_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready = 1'b1;
  logic [3:0]  digit_count;
  logic        err;

  int checks = 0;
  int errors = 0;
  int nerr = 0;
  int ncoinc = 0;
  logic [31:0] wq[$];

  ascii_hex_parser #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .digit_count(digit_count), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (word_valid && word_ready) wq.push_back(word_data);
    if (err) nerr++;
    if (err && word_valid) ncoinc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    int t = 0;
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = c;
    while (!char_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic clear_log();
    @(negedge clk);
    wq.delete();
    nerr = 0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int bad;
    // reset values
    #12;
    chk("rst_char_ready", 32'(char_ready), 32'd0);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_data", word_data, 32'd0);
    chk("rst_digit_count", 32'(digit_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(char_ready), 32'd1);

    // basic word, word_valid visible right after the terminator edge
    clear_log();
    send_str("1A2F");
    chk("cnt_1A2F", 32'(digit_count), 32'd4);
    send(8'h0D);
    chk("wv_after_cr", 32'(word_valid), 32'd1);
    chk("wd_after_cr", word_data, 32'h0000_1A2F);
    settle();
    chk("n_words_1A2F", 32'(wq.size()), 32'd1);
    chk("word_1A2F", wq.size() > 0 ? wq[0] : 32'hx, 32'h0000_1A2F);
    chk("noerr_1A2F", 32'(nerr), 32'd0);
    chk("cnt_after_hold", 32'(digit_count), 32'd0);

    // full-width word, trailing LF ignored
    clear_log();
    send_str("DEADBEEF\r\n");
    settle();
    chk("n_words_dead", 32'(wq.size()), 32'd1);
    chk("word_dead", wq.size() > 0 ? wq[0] : 32'hx, 32'hDEAD_BEEF);

    // overflow: ninth digit discards entry
    clear_log();
    send_str("123456789\r");
    chk("err_after_ovf", 32'(err), 32'd1);
    settle();
    chk("n_words_ovf", 32'(wq.size()), 32'd0);
    chk("nerr_ovf", 32'(nerr), 32'd1);

    // illegal char, then good entry
    clear_log();
    send_str("12G");
    chk("cnt_discard", 32'(digit_count), 32'd0);
    send_str("4 ");
    chk("err_after_sp", 32'(err), 32'd1);
    send_str("7\n");
    settle();
    chk("nerr_illegal", 32'(nerr), 32'd1);
    chk("n_words_7", 32'(wq.size()), 32'd1);
    chk("word_7", wq.size() > 0 ? wq[0] : 32'hx, 32'h7);

    // backpressure: word held stable, input stalled
    clear_log();
    word_ready = 1'b0;
    send_str("55\r");
    @(negedge clk);
    char_valid = 1'b1;
    char_data  = "6";
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (char_ready !== 1'b0 || word_valid !== 1'b1 || word_data !== 32'h55) bad++;
    end
    chk("stall_hold", 32'(bad), 32'd0);
    word_ready = 1'b1;
    send_str("66\r");
    settle();
    chk("n_words_bp", 32'(wq.size()), 32'd2);
    chk("word_55", wq.size() > 0 ? wq[0] : 32'hx, 32'h55);
    chk("word_66", wq.size() > 1 ? wq[1] : 32'hx, 32'h66);

    // lowercase
    clear_log();
    send_str("ab\r");
    settle();
`ifdef ASCII_PARSER_LOWERCASE_EN
    chk("n_words_ab", 32'(wq.size()), 32'd1);
    chk("word_ab", wq.size() > 0 ? wq[0] : 32'hx, 32'hAB);
    chk("nerr_ab", 32'(nerr), 32'd0);
`else
    chk("n_words_ab", 32'(wq.size()), 32'd0);
    chk("nerr_ab", 32'(nerr), 32'd1);
`endif

    // reset mid-entry
    clear_log();
    send_str("12");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(char_ready), 32'd0);
    chk("midrst_cnt", 32'(digit_count), 32'd0);
    chk("midrst_wv", 32'(word_valid), 32'd0);
    chk("midrst_wd", word_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_str("3\r");
    settle();
    chk("n_words_3", 32'(wq.size()), 32'd1);
    chk("word_3", wq.size() > 0 ? wq[0] : 32'hx, 32'h3);
    chk("nerr_midrst", 32'(nerr), 32'd0);
    chk("err_wv_coincide", 32'(ncoinc), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
